// File: rtl/bf_mem_arbiter.sv
// bf_mem_arbiter
//   Merges the bfcpu instruction-fetch port (i_*) and data port (d_*) onto one
//   shared memory port (m_*). Round-robin arbitration between the two ports,
//   the 8-bit data address is mapped into the 256-byte window at
//   DATA_BASE[15:8], and a watchdog ends a transaction that never sees m_ack.
//
// Parameters
//   DATA_BASE  base of the data window (only bits [15:8] are used)
//   TIMEOUT    cycles to wait for m_ack before giving up (2..65535)
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   i_req, i_addr         instruction read request (level) and address
//   i_ack, i_rdata        one-cycle completion pulse, fetched byte (held)
//   d_req, d_dir          data request (level), 1 = write
//   d_addr, d_wdata       data address (window offset) and write data
//   d_ack, d_rdata        one-cycle completion pulse, read byte (held)
//   m_req, m_dir          shared memory request (level) and direction
//   m_addr, m_wdata       shared memory address and write data
//   m_ack, m_rdata        memory completion; m_rdata valid with m_ack
//   err                   sticky timeout flag, cleared only by reset
//   dbg_state             current FSM state encoding
//
// Handshake: a requester raises req with stable address/dir/wdata and keeps
// them stable until it samples ack=1; ack is a single-cycle pulse. The ACK
// state between completion and IDLE gives the requester one cycle to drop or
// replace req, so a req still high on the ack edge is never served twice.
// On the memory side m_req is held with stable m_addr/m_dir/m_wdata until the
// memory returns m_ack (or the watchdog expires); m_ack outside a busy state
// is ignored.
module bf_mem_arbiter #(
    parameter logic [15:0] DATA_BASE = 16'hFF00,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_ack,
    output logic [7:0]  i_rdata,
    input  logic        d_req,
    input  logic        d_dir,
    input  logic [7:0]  d_addr,
    input  logic [7:0]  d_wdata,
    output logic        d_ack,
    output logic [7:0]  d_rdata,
    output logic        m_req,
    output logic        m_dir,
    output logic [15:0] m_addr,
    output logic [7:0]  m_wdata,
    input  logic        m_ack,
    input  logic [7:0]  m_rdata,
    output logic        err,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BUSY_I = 3'd1,
        ST_BUSY_D = 3'd2,
        ST_ACK_I  = 3'd3,
        ST_ACK_D  = 3'd4
    } state_t;

    // Counter value on the last cycle the memory is allowed to answer.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_nx;
    logic        last_d_q, last_d_nx;   // 1: data port was granted most recently
    logic [15:0] cnt_q, cnt_nx;
    logic        m_dir_nx;
    logic [15:0] m_addr_nx;
    logic [7:0]  m_wdata_nx;
    logic [7:0]  i_rdata_nx, d_rdata_nx;
    logic        err_nx;
    logic        grant_i;

    always_comb begin
        state_nx   = state_q;
        last_d_nx  = last_d_q;
        cnt_nx     = cnt_q;
        m_dir_nx   = m_dir;
        m_addr_nx  = m_addr;
        m_wdata_nx = m_wdata;
        i_rdata_nx = i_rdata;
        d_rdata_nx = d_rdata;
        err_nx     = err;
        // Instruction port wins when alone, or when contested and the data
        // port had the previous grant.
        grant_i    = i_req && (!d_req || last_d_q);

        case (state_q)
            ST_IDLE: begin
                if (grant_i) begin
                    state_nx   = ST_BUSY_I;
                    m_addr_nx  = i_addr;
                    m_dir_nx   = 1'b0;
                    m_wdata_nx = 8'h00;
                    cnt_nx     = 16'd0;
                    last_d_nx  = 1'b0;
                end else if (d_req) begin
                    state_nx   = ST_BUSY_D;
                    m_addr_nx  = {DATA_BASE[15:8], d_addr};
                    m_dir_nx   = d_dir;
                    m_wdata_nx = d_wdata;
                    cnt_nx     = 16'd0;
                    last_d_nx  = 1'b1;
                end
            end
            ST_BUSY_I: begin
                // m_ack takes priority over an expiry on the same cycle.
                if (m_ack) begin
                    i_rdata_nx = m_rdata;
                    state_nx   = ST_ACK_I;
                end else if (cnt_q == TMO_LAST) begin
                    i_rdata_nx = 8'hFF;
                    err_nx     = 1'b1;
                    state_nx   = ST_ACK_I;
                end else if (cnt_q != 16'hFFFF) begin
                    cnt_nx = cnt_q + 16'd1;
                end
            end
            ST_BUSY_D: begin
                if (m_ack) begin
                    if (!m_dir) d_rdata_nx = m_rdata;
                    state_nx = ST_ACK_D;
                end else if (cnt_q == TMO_LAST) begin
                    if (!m_dir) d_rdata_nx = 8'hFF;
                    err_nx   = 1'b1;
                    state_nx = ST_ACK_D;
                end else if (cnt_q != 16'hFFFF) begin
                    cnt_nx = cnt_q + 16'd1;
                end
            end
            ST_ACK_I, ST_ACK_D: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            last_d_q <= 1'b1;
            cnt_q    <= 16'd0;
            m_dir    <= 1'b0;
            m_addr   <= 16'h0000;
            m_wdata  <= 8'h00;
            i_rdata  <= 8'h00;
            d_rdata  <= 8'h00;
            err      <= 1'b0;
        end else begin
            state_q  <= state_nx;
            last_d_q <= last_d_nx;
            cnt_q    <= cnt_nx;
            m_dir    <= m_dir_nx;
            m_addr   <= m_addr_nx;
            m_wdata  <= m_wdata_nx;
            i_rdata  <= i_rdata_nx;
            d_rdata  <= d_rdata_nx;
            err      <= err_nx;
        end
    end

    // Pure decodes of the state register: no input reaches an output without
    // passing through a flop, and reset drops m_req asynchronously.
    assign m_req     = (state_q == ST_BUSY_I) || (state_q == ST_BUSY_D);
    assign i_ack     = (state_q == ST_ACK_I);
    assign d_ack     = (state_q == ST_ACK_D);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bf_mem_arbiter.sv
module tb_bf_mem_arbiter;

  localparam int          TMO   = 8;
  localparam logic [7:0]  DB_HI = 8'hFF;

  logic        clk;
  logic        rst_n;
  logic        i_req = 1'b0;
  logic [15:0] i_addr = 16'h0000;
  logic        i_ack;
  logic [7:0]  i_rdata;
  logic        d_req = 1'b0;
  logic        d_dir = 1'b0;
  logic [7:0]  d_addr = 8'h00;
  logic [7:0]  d_wdata = 8'h00;
  logic        d_ack;
  logic [7:0]  d_rdata;
  logic        m_req;
  logic        m_dir;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata;
  logic        m_ack = 1'b0;
  logic [7:0]  m_rdata = 8'h00;
  logic        err;
  logic [2:0]  dbg_state;

  bf_mem_arbiter #(.DATA_BASE(16'hFF00), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_dir(d_dir), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_req(m_req), .m_dir(m_dir), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata),
    .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // ---------------- counters and check ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory model and reference memory ----------------
  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];
  int  mem_lat   = 1;     // 0: never acknowledge
  bit  mem_rand  = 1'b0;  // pick latency 1..4 per transaction
  bit  force_ack = 1'b0;  // stray m_ack with no transaction
  int  mcnt      = 0;
  int  cur_lat   = 1;

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
  endfunction

  // Acks on the N-th clock edge after the one that raised m_req.
  always @(posedge clk) begin
    #1;
    if (m_req) begin
      if (mcnt == 0) cur_lat = mem_rand ? int'($urandom_range(1, 4)) : mem_lat;
      mcnt++;
      if (cur_lat != 0 && mcnt == cur_lat) begin
        m_ack   = 1'b1;
        m_rdata = mem[m_addr];
        if (m_dir) mem[m_addr] = m_wdata;
      end else begin
        m_ack   = force_ack;
        m_rdata = 8'hA5;
      end
    end else begin
      mcnt    = 0;
      m_ack   = force_ack;
      m_rdata = 8'hA5;
    end
  end

  // ---------------- scoreboard: expected memory transactions ----------------
  logic [24:0] exp_q_i[$];   // {dir, addr, wdata} per instruction request
  logic [24:0] exp_q_d[$];
  bit          grant_log[$]; // 0 = instruction, 1 = data
  bit i_wait = 1'b0, d_wait = 1'b0;
  bit req_i_s, req_d_s, wait_i_s, wait_d_s;
  bit mreq_prev = 1'b0, iack_prev = 1'b0, dack_prev = 1'b0;
  bit tx_open = 1'b0, last_grant = 1'b1, gport;
  int n_gi = 0, n_gd = 0;
  logic [24:0] e;

  always @(posedge clk) begin
    req_i_s  = i_req;
    req_d_s  = d_req;
    wait_i_s = i_wait;
    wait_d_s = d_wait;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      mreq_prev = 1'b0; iack_prev = 1'b0; dack_prev = 1'b0;
      tx_open = 1'b0; last_grant = 1'b1;
    end else begin
      if (m_req && !mreq_prev) begin
        gport = (m_addr[15:8] == DB_HI);
        check("ack_between_txns", {31'd0, tx_open}, 0);
        tx_open = 1'b1;
        check("grant_has_req", {31'd0, req_i_s | req_d_s}, 1);
        if (req_i_s && req_d_s) check("rr_grant", {31'd0, gport}, {31'd0, !last_grant});
        else                    check("sole_grant", {31'd0, gport}, {31'd0, req_d_s});
        last_grant = gport;
        grant_log.push_back(gport);
        if (gport) begin
          n_gd++;
          check("d_txn_queued", {31'd0, exp_q_d.size() != 0}, 1);
          if (exp_q_d.size() != 0) begin
            e = exp_q_d.pop_front();
            check("d_txn_fields", {7'd0, m_dir, m_addr, m_wdata}, {7'd0, e});
          end
        end else begin
          n_gi++;
          check("i_txn_queued", {31'd0, exp_q_i.size() != 0}, 1);
          if (exp_q_i.size() != 0) begin
            e = exp_q_i.pop_front();
            check("i_txn_fields", {7'd0, m_dir, m_addr, m_wdata}, {7'd0, e});
          end
        end
      end
      if (i_ack) begin
        check("i_ack_one_cycle", {31'd0, iack_prev}, 0);
        check("i_ack_wanted", {31'd0, wait_i_s}, 1);
        tx_open = 1'b0;
      end
      if (d_ack) begin
        check("d_ack_one_cycle", {31'd0, dack_prev}, 0);
        check("d_ack_wanted", {31'd0, wait_d_s}, 1);
        tx_open = 1'b0;
      end
      mreq_prev = m_req; iack_prev = i_ack; dack_prev = d_ack;
    end
  end

  // ---------------- driver tasks ----------------
  // Called on a falling edge; returns on the falling edge where ack was seen.
  task automatic do_txn(input bit is_d, input bit dir, input logic [15:0] addr,
                        input logic [7:0] wd, output logic [7:0] rd, output int cyc);
    bit got;
    got = 1'b0; rd = 8'h00; cyc = 0;
    if (is_d) begin
      exp_q_d.push_back({dir, DB_HI, addr[7:0], wd});
      d_dir = dir; d_addr = addr[7:0]; d_wdata = wd; d_req = 1'b1; d_wait = 1'b1;
    end else begin
      exp_q_i.push_back({1'b0, addr, 8'h00});
      i_addr = addr; i_req = 1'b1; i_wait = 1'b1;
    end
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (is_d ? d_ack : i_ack) begin
        got = 1'b1;
        rd  = is_d ? d_rdata : i_rdata;
      end
    end
    check(is_d ? "d_ack_arrives" : "i_ack_arrives", {31'd0, got}, 1);
    if (is_d) begin
      d_req = 1'b0; d_wait = 1'b0;
      if (got && dir) ref_mem[{DB_HI, addr[7:0]}] = wd;
    end else begin
      i_req = 1'b0; i_wait = 1'b0;
    end
  endtask

  task automatic do_reset();
    i_req = 1'b0; d_req = 1'b0; i_wait = 1'b0; d_wait = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_req"},   {31'd0, m_req}, 0);
    check({tag, "_m_dir"},   {31'd0, m_dir}, 0);
    check({tag, "_m_addr"},  {16'd0, m_addr}, 0);
    check({tag, "_m_wdata"}, {24'd0, m_wdata}, 0);
    check({tag, "_i_ack"},   {31'd0, i_ack}, 0);
    check({tag, "_d_ack"},   {31'd0, d_ack}, 0);
    check({tag, "_i_rdata"}, {24'd0, i_rdata}, 0);
    check({tag, "_d_rdata"}, {24'd0, d_rdata}, 0);
    check({tag, "_err"},     {31'd0, err}, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          is_d;
    bit          dir;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          lat;
    logic [7:0]  exp_rd;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[9];
  logic [7:0] rd_a, rd_b, ex_a, ex_b, hold_i, hold_d;
  logic [15:0] ad_a, ad_b;
  int cyc_a, cyc_b, g0, gi0;
  bit dir_b;
  bit exp_pat[4];

  initial begin
    rst_n = 1'b0;
    for (int a = 0; a < 65536; a++) begin
      mem[a]     = init_byte(16'(a));
      ref_mem[a] = init_byte(16'(a));
    end
    mem[16'h0123] = 8'h2B; ref_mem[16'h0123] = 8'h2B;
    mem[16'h4000] = 8'hC3; ref_mem[16'h4000] = 8'hC3;
    mem[16'hFF00] = 8'h77; ref_mem[16'hFF00] = 8'h77;
    mem[16'h0200] = 8'h5E; ref_mem[16'h0200] = 8'h5E;
    mem[16'hFEFF] = 8'h11; ref_mem[16'hFEFF] = 8'h11;

    //            is_d dir addr      wdata  lat rd     cyc
    vecs[0] = '{1'b0, 1'b0, 16'h0123, 8'h00, 1, 8'h2B, 2};
    vecs[1] = '{1'b1, 1'b1, 16'h0005, 8'h41, 1, 8'h00, 2};
    vecs[2] = '{1'b1, 1'b0, 16'h0005, 8'h00, 1, 8'h41, 2};
    vecs[3] = '{1'b0, 1'b0, 16'h4000, 8'h00, 3, 8'hC3, 4};
    vecs[4] = '{1'b1, 1'b1, 16'h00FF, 8'h9E, 2, 8'h00, 3};
    vecs[5] = '{1'b1, 1'b0, 16'h00FF, 8'h00, 4, 8'h9E, 5};
    vecs[6] = '{1'b1, 1'b0, 16'h0000, 8'h00, 8, 8'h77, 9};  // answer on the last allowed cycle
    vecs[7] = '{1'b0, 1'b0, 16'h0200, 8'h00, 7, 8'h5E, 8};
    vecs[8] = '{1'b0, 1'b0, 16'hFEFF, 8'h00, 2, 8'h11, 3};
    exp_pat = '{1'b0, 1'b1, 1'b0, 1'b1};

    // power-on reset values
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);

    // contention from reset: both held for two transactions each
    mem_lat = 1;
    g0 = grant_log.size();
    fork
      begin
        for (int k = 0; k < 2; k++) begin
          ad_a = 16'h0010 + 16'(k); ex_a = ref_mem[ad_a];
          do_txn(1'b0, 1'b0, ad_a, 8'h00, rd_a, cyc_a);
          check("cont_i_rdata", {24'd0, rd_a}, {24'd0, ex_a});
        end
      end
      begin
        for (int k = 0; k < 2; k++) begin
          ad_b = 16'h0001 + 16'(k); ex_b = ref_mem[{DB_HI, ad_b[7:0]}];
          do_txn(1'b1, 1'b0, ad_b, 8'h00, rd_b, cyc_b);
          check("cont_d_rdata", {24'd0, rd_b}, {24'd0, ex_b});
        end
      end
    join
    check("cont_grants", grant_log.size() - g0, 4);
    for (int k = 0; k < 4; k++)
      if (grant_log.size() > g0 + k)
        check($sformatf("cont_order_%0d", k), {31'd0, grant_log[g0 + k]}, {31'd0, exp_pat[k]});

    // table-driven single transactions
    do_reset();
    hold_i = 8'h00; hold_d = 8'h00;
    for (int k = 0; k < 9; k++) begin
      mem_lat = vecs[k].lat;
      do_txn(vecs[k].is_d, vecs[k].dir, vecs[k].addr, vecs[k].wdata, rd_a, cyc_a);
      check($sformatf("vec%0d_cycles", k), cyc_a, vecs[k].exp_cyc);
      if (!vecs[k].dir) begin
        check($sformatf("vec%0d_rdata", k), {24'd0, rd_a}, {24'd0, vecs[k].exp_rd});
        if (vecs[k].is_d) hold_d = vecs[k].exp_rd;
        else              hold_i = vecs[k].exp_rd;
      end
      @(negedge clk);
      check($sformatf("vec%0d_i_hold", k), {24'd0, i_rdata}, {24'd0, hold_i});
      check($sformatf("vec%0d_d_hold", k), {24'd0, d_rdata}, {24'd0, hold_d});
    end
    check("table_err", {31'd0, err}, 0);

    // held instruction request for three fetches
    mem_lat = 2;
    gi0 = n_gi;
    ex_a = ref_mem[16'h0456];
    for (int k = 0; k < 3; k++) begin
      do_txn(1'b0, 1'b0, 16'h0456, 8'h00, rd_a, cyc_a);
      check($sformatf("held%0d_cycles", k), cyc_a, (k == 0) ? 3 : 4);
      check($sformatf("held%0d_rdata", k), {24'd0, rd_a}, {24'd0, ex_a});
    end
    repeat (6) @(negedge clk);
    check("held_grant_count", n_gi - gi0, 3);

    // timeout on a data read, then a stray m_ack, then normal recovery
    mem_lat = 0;
    do_txn(1'b1, 1'b0, 16'h0010, 8'h00, rd_a, cyc_a);
    check("tmo_cycles", cyc_a, TMO + 1);
    check("tmo_rdata", {24'd0, rd_a}, 32'h0000_00FF);
    check("tmo_err", {31'd0, err}, 1);
    force_ack = 1'b1;
    repeat (3) @(negedge clk);
    force_ack = 1'b0;
    @(negedge clk);
    check("late_ack_d_rdata", {24'd0, d_rdata}, 32'h0000_00FF);
    check("late_ack_err", {31'd0, err}, 1);
    check("late_ack_no_req", {31'd0, m_req}, 0);
    mem_lat = 1;
    do_txn(1'b1, 1'b1, 16'h0010, 8'h3C, rd_a, cyc_a);
    check("recover_wr_cycles", cyc_a, 2);
    do_txn(1'b1, 1'b0, 16'h0010, 8'h00, rd_a, cyc_a);
    check("recover_rd_rdata", {24'd0, rd_a}, 32'h0000_003C);
    check("recover_err_sticky", {31'd0, err}, 1);

    // reset in the middle of a data transaction
    mem_lat = 0;
    exp_q_d.push_back({1'b0, DB_HI, 8'h20, 8'h00});
    d_dir = 1'b0; d_addr = 8'h20; d_wdata = 8'h00; d_req = 1'b1; d_wait = 1'b1;
    repeat (3) @(negedge clk);
    check("midop_busy", {31'd0, m_req}, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midop");
    d_req = 1'b0; d_wait = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midop_no_ack", {30'd0, i_ack, d_ack}, 0);
    rst_n = 1'b1;
    mem_lat = 1;
    g0 = grant_log.size();
    ex_a = ref_mem[16'h0300];
    ex_b = ref_mem[{DB_HI, 8'h10}];
    fork
      do_txn(1'b0, 1'b0, 16'h0300, 8'h00, rd_a, cyc_a);
      do_txn(1'b1, 1'b0, 16'h0010, 8'h00, rd_b, cyc_b);
    join
    check("post_reset_grants", grant_log.size() - g0, 2);
    if (grant_log.size() > g0)
      check("post_reset_first_is_i", {31'd0, grant_log[g0]}, 0);
    check("post_reset_i_rdata", {24'd0, rd_a}, {24'd0, ex_a});
    check("post_reset_d_rdata", {24'd0, rd_b}, {24'd0, ex_b});

    // randomized traffic on both ports against the reference memory
    mem_rand = 1'b1;
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          ad_a = 16'($urandom_range(0, 32'hFEFF));
          ex_a = ref_mem[ad_a];
          do_txn(1'b0, 1'b0, ad_a, 8'h00, rd_a, cyc_a);
          check("rand_i_rdata", {24'd0, rd_a}, {24'd0, ex_a});
        end
      end
      begin
        for (int k = 0; k < 30; k++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          dir_b = 1'($urandom_range(0, 1));
          ad_b  = 16'($urandom_range(0, 7));
          ex_b  = ref_mem[{DB_HI, ad_b[7:0]}];
          do_txn(1'b1, dir_b, ad_b, 8'($urandom_range(0, 255)), rd_b, cyc_b);
          if (!dir_b) check("rand_d_rdata", {24'd0, rd_b}, {24'd0, ex_b});
        end
      end
    join
    mem_rand = 1'b0;
    repeat (4) @(negedge clk);
    check("rand_err_clear", {31'd0, err}, 0);
    check("exp_q_i_empty", exp_q_i.size(), 0);
    check("exp_q_d_empty", exp_q_d.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
